fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of mem_unit.
- Holds the PC and issues word reads to mem_unit's read port (en/addr/data).
- Absorbs mem_unit's 1-cycle read latency and buffers returned words with their PC in a small FIFO.
- Hands instructions to decode over a valid/ready handshake; supports branch redirect with flush.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and the buffered fetch entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int DEF_ADDR_W   = 11;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RESET_PC = 0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; flush beats push, pointers wrap modulo DEPTH.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter int  CNT_W   = $clog2(DEPTH + 1),
  parameter type entry_t = fetch_entry_t
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      // Stale entries stay in storage; they are unreachable once the pointers reset.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The issue logic upstream reserves a slot for every request, so a push into a full buffer is a bug.
  no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !flush_i && full && !pop_i));

  no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && empty_o && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-cycle-latency word reads and buffers
// returned words with their PC for decode; a redirect flushes everything and restarts at a new PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RESET_PC  = DEF_RESET_PC,
  parameter int BUF_DEPTH = 2              // must be >= 2 for full throughput
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_en_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  count;
  logic              empty;
  entry_t            head;
  entry_t            push_entry;
  logic              pop;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occupancy;
  logic [OCC_W-1:0]  limit;

  // Decode handshake: an instruction transfers on every rising edge where instr_valid_o and
  // instr_ready_i are both high; while valid is high and ready low, instr_o/instr_pc_o hold
  // (unless a redirect flushes them). Valid never depends on ready.
  assign instr_valid_o = rst_ni && !empty;
  assign pop           = instr_valid_o && instr_ready_i;

  // Every buffered word and every word still in flight owns a slot; a same-cycle pop frees one,
  // which keeps one instruction per cycle flowing with a two-entry buffer.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight_q);
  assign limit     = OCC_W'(BUF_DEPTH) + OCC_W'(pop);
  assign issue     = rst_ni && !redirect_i && (occupancy < limit);

  assign mem_en_o   = issue;
  assign mem_wr_o   = 1'b0;
  assign mem_addr_o = pc_q;

  assign push             = inflight_q && !redirect_i;
  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = mem_data_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q       <= ADDR_W'(RESET_PC);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q       <= redirect_pc_i;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + ADDR_W'(1);
        req_pc_q <= pc_q;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (BUF_DEPTH),
    .CNT_W   (CNT_W),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty)
  );

  assign instr_o    = head.instr;
  assign instr_pc_o = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for the directed corner cases, then random traffic
// checked by an in-order scoreboard of expected fetch PCs.
module tb_fetch_unit;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int BUF_DEPTH = 2;
  localparam int MEM_WORDS = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n     = 1'b0;
  logic              redirect  = 1'b0;
  logic [ADDR_W-1:0] redir_pc  = '0;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data  = '0;
  logic              valid;
  logic              ready     = 1'b0;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  fetch_unit #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RESET_PC  (0),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redir_pc),
    .mem_en_o      (mem_en),
    .mem_wr_o      (mem_wr),
    .mem_addr_o    (mem_addr),
    .mem_data_i    (mem_data),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc)
  );

  // Memory with one-cycle read latency, preloaded word[i] = 0x1000 + i.
  logic [DATA_W-1:0] mem_words [MEM_WORDS];
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_words[i] = 32'h1000 + i;
  end
  always @(posedge clk) if (mem_en) mem_data <= mem_words[mem_addr];

  int tests_run = 0;
  int failed    = 0;
  int hs_count  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic rd, input logic [ADDR_W-1:0] rpc, input logic rdy);
    @(negedge clk);
    rst_n    = r;
    redirect = rd;
    redir_pc = rpc;
    ready    = rdy;
  endtask

  // ---------------- scoreboard ----------------
  // Expected PCs in delivery order; every issued request owes decode exactly one word.
  logic [ADDR_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] fetch_pc  = '0;
  logic              prev_hold = 1'b0;
  logic [ADDR_W-1:0] prev_pc   = '0;
  logic [DATA_W-1:0] prev_instr = '0;

  always @(negedge clk) begin
    logic [ADDR_W-1:0] exp_pc;
    #2;
    check("mem_wr_tied_low", mem_wr, 1'b0);
    if (!rst_n) begin
      check("reset_valid_low", valid, 1'b0);
      check("reset_en_low", mem_en, 1'b0);
      exp_q.delete();
      fetch_pc  = '0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", valid, 1'b1);
        check("hold_pc", instr_pc, prev_pc);
        check("hold_instr", instr, prev_instr);
      end
      if (valid && ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("delivery_unexpected", instr_pc, {ADDR_W{1'bx}});
        end else begin
          exp_pc = exp_q.pop_front();
          check("delivery_pc", instr_pc, exp_pc);
          check("delivery_instr", instr, mem_words[exp_pc]);
        end
      end
      if (mem_en) begin
        check("issue_addr", mem_addr, fetch_pc);
        exp_q.push_back(fetch_pc);
        fetch_pc = fetch_pc + 1'b1;
        check("outstanding_bound", exp_q.size() <= BUF_DEPTH, 1'b1);
      end
      if (redirect) begin
        exp_q.delete();
        fetch_pc = redir_pc;
      end
      prev_hold  = valid && !ready && !redirect;
      prev_pc    = instr_pc;
      prev_instr = instr;
    end
  end

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic              rst_n;
    logic              redir;
    logic [ADDR_W-1:0] rpc;
    logic              rdy;
    logic              exp_en;
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_pc;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic r, input logic rd, input int rpc, input logic rdy,
                     input logic en, input logic v, input int pc, input int reps = 1);
    vec_t e;
    for (int k = 0; k < reps; k++) begin
      e.rst_n = r; e.redir = rd; e.rpc = ADDR_W'(rpc); e.rdy = rdy;
      e.exp_en = en; e.exp_valid = v; e.exp_pc = ADDR_W'(pc);
      vecs.push_back(e);
    end
  endtask

  initial begin
    // Reset then stream with no bubbles.
    add(0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 0, 0, 1, 1, 0, 0, 2);
    for (int p = 0; p < 4; p++) add(1, 0, 0, 1, 1, 1, p);
    // Backpressure: buffer fills, requests stop, head holds.
    add(1, 0, 0, 0, 0, 1, 4, 6);
    for (int p = 4; p < 8; p++) add(1, 0, 0, 1, 1, 1, p);
    // Redirect with buffered entry plus a request in flight.
    add(1, 1, 'h100, 0, 0, 1, 8);
    add(1, 0, 0, 1, 1, 0, 0, 2);
    for (int p = 'h100; p < 'h103; p++) add(1, 0, 0, 1, 1, 1, p);
    // Redirect together with a handshake, landing on the wrap point.
    add(1, 1, 'h7FE, 1, 0, 1, 'h103);
    add(1, 0, 0, 1, 1, 0, 0, 2);
    add(1, 0, 0, 1, 1, 1, 'h7FE);
    add(1, 0, 0, 1, 1, 1, 'h7FF);
    add(1, 0, 0, 1, 1, 1, 'h000);
    add(1, 0, 0, 1, 1, 1, 'h001);
    // One-cycle reset while valid and a request are both live.
    add(0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 2);
    add(1, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 1, 1, 1, 1);
    // Back-to-back redirects: the second wins.
    add(1, 1, 'h050, 1, 0, 1, 2);
    add(1, 1, 'h200, 1, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 2);
    add(1, 0, 0, 1, 1, 1, 'h200);
    add(1, 0, 0, 1, 1, 1, 'h201);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
      #1;
      check($sformatf("vec%0d_en", i), mem_en, vecs[i].exp_en);
      check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_instr", i), instr, 32'h1000 + 32'(vecs[i].exp_pc));
      end
    end

    // ---------------- random traffic ----------------
    for (int c = 0; c < 3000; c++) begin
      logic              r;
      logic              rd;
      logic [ADDR_W-1:0] rpc;
      r   = ($urandom_range(0, 199) != 0);
      rd  = ($urandom_range(0, 29) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(2040, 2047))
                                        : ADDR_W'($urandom_range(0, MEM_WORDS - 1));
      drive(r, rd, rpc, $urandom_range(0, 9) < 7);
    end
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);
    @(negedge clk);
    #3;
    check("random_traffic_flowed", hs_count > 1000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
